// File: rtl/spmv_pkg.sv
// Shared types and default geometry for the sparse MxV sequencer.
// State encoding and the default depths used by spmv_seq_ctrl.
package spmv_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_DRAIN,
        ST_WAIT,
        ST_OUT,
        ST_DONE
    } state_t;

    localparam int DEF_IN_DEPTH  = 64;
    localparam int DEF_OUT_DEPTH = 1024;
    localparam int DEF_PIPE_LAT  = 16;
    localparam int DEF_NUM_CH    = 4;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/spmv_phase_cnt.sv
// Loadable down-counter with a zero flag; load wins over decrement, holds at zero.
// Single-cycle update, no backpressure (en simply pauses the count).
module spmv_phase_cnt #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic [W-1:0] cnt,
    output logic         zero
);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en && cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/spmv_seq_ctrl.sv
// Sparse MxV sequencer: load input vector, drain read/datapath latency, write NUM_CH results.
// First out_we 1+IN_DEPTH+RD_LAT+PIPE_LAT cycles after start; out_stall freezes OUT only.
module spmv_seq_ctrl
    import spmv_pkg::*;
#(
    parameter int IN_DEPTH  = DEF_IN_DEPTH,
    parameter int IN_AW     = 8,
    parameter int RD_LAT    = 3,
    parameter int PIPE_LAT  = DEF_PIPE_LAT,
    parameter int OUT_DEPTH = DEF_OUT_DEPTH,
    parameter int OUT_AW    = 11,
    parameter int NUM_CH    = DEF_NUM_CH,
    parameter int DRV_LEAD  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [7:0]        cfg_batches,
    input  logic [NUM_CH-1:0] ch_mask,
    input  logic              out_stall,
    output logic              busy,
    output logic              done,
    output logic              in_en,
    output logic [IN_AW-1:0]  in_addr,
    output logic [NUM_CH-1:0] out_en,
    output logic [NUM_CH-1:0] out_we,
    output logic [OUT_AW-1:0] out_addr,
    output logic              out_valid,
    output logic              drv_en,
    output logic [7:0]        batch_idx
);

    if (OUT_DEPTH > (1 << OUT_AW)) begin : g_chk_out_depth
        $error("OUT_DEPTH does not fit in OUT_AW address bits");
    end
    if (IN_DEPTH > (1 << IN_AW)) begin : g_chk_in_depth
        $error("IN_DEPTH does not fit in IN_AW address bits");
    end
    if (DRV_LEAD >= PIPE_LAT) begin : g_chk_lead_pipe
        $error("DRV_LEAD must be smaller than PIPE_LAT");
    end
    if (DRV_LEAD >= OUT_DEPTH) begin : g_chk_lead_out
        $error("DRV_LEAD must be smaller than OUT_DEPTH");
    end
    if (RD_LAT < 1 || IN_DEPTH < 1) begin : g_chk_min
        $error("RD_LAT and IN_DEPTH must be at least 1");
    end

    localparam int CNT_MAX = max3(IN_DEPTH, RD_LAT, PIPE_LAT);
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0]  LOAD_LEN  = CNT_W'(IN_DEPTH - 1);
    localparam logic [CNT_W-1:0]  DRAIN_LEN = CNT_W'(RD_LAT - 1);
    localparam logic [CNT_W-1:0]  WAIT_LEN  = CNT_W'(PIPE_LAT - 1);
    localparam logic [CNT_W-1:0]  LEAD_CNT  = CNT_W'(DRV_LEAD);
    localparam logic [OUT_AW-1:0] OUT_LAST  = OUT_AW'(OUT_DEPTH - 1);
    localparam logic [OUT_AW:0]   DRV_STOP  = (OUT_AW + 1)'(OUT_DEPTH - DRV_LEAD);

    state_t              state, state_nxt;
    logic [IN_AW-1:0]    in_addr_q;
    logic [OUT_AW-1:0]   out_addr_q;
    logic [7:0]          batch_q;
    logic [7:0]          last_batch_q;
    logic [NUM_CH-1:0]   mask_q;
    logic                cnt_load;
    logic                cnt_en;
    logic [CNT_W-1:0]    cnt_val;
    logic [CNT_W-1:0]    cnt;
    logic                cnt_zero;
    logic                out_last;
    logic                out_step;

    // One counter times LOAD, DRAIN and WAIT; each phase reloads it on exit.
    spmv_phase_cnt #(
        .W (CNT_W)
    ) u_phase_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (cnt_val),
        .en       (cnt_en),
        .cnt      (cnt),
        .zero     (cnt_zero)
    );

    assign out_last = (out_addr_q == OUT_LAST);
    assign out_step = (state == ST_OUT) && !out_stall;

    always_comb begin
        state_nxt = state;
        cnt_load  = 1'b0;
        cnt_en    = 1'b0;
        cnt_val   = '0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = ST_LOAD;
                    cnt_load  = 1'b1;
                    cnt_val   = LOAD_LEN;
                end
            end
            ST_LOAD: begin
                cnt_en = 1'b1;
                if (cnt_zero) begin
                    state_nxt = ST_DRAIN;
                    cnt_load  = 1'b1;
                    cnt_val   = DRAIN_LEN;
                end
            end
            ST_DRAIN: begin
                cnt_en = 1'b1;
                if (cnt_zero) begin
                    state_nxt = ST_WAIT;
                    cnt_load  = 1'b1;
                    cnt_val   = WAIT_LEN;
                end
            end
            ST_WAIT: begin
                cnt_en = 1'b1;
                if (cnt_zero) begin
                    state_nxt = ST_OUT;
                end
            end
            ST_OUT: begin
                if (out_step && out_last) begin
                    if (batch_q == last_batch_q) begin
                        state_nxt = ST_DONE;
                    end else begin
                        state_nxt = ST_LOAD;
                        cnt_load  = 1'b1;
                        cnt_val   = LOAD_LEN;
                    end
                end
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
        if (abort && state != ST_IDLE) begin
            state_nxt = ST_IDLE;
            cnt_load  = 1'b0;
            cnt_en    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            in_addr_q    <= '0;
            out_addr_q   <= '0;
            batch_q      <= '0;
            last_batch_q <= '0;
            mask_q       <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_IDLE && start) begin
                in_addr_q    <= '0;
                out_addr_q   <= '0;
                batch_q      <= '0;
                mask_q       <= ch_mask;
                last_batch_q <= (cfg_batches == 8'd0) ? 8'd0 : cfg_batches - 8'd1;
            end
            // in_addr is never rewound between batches, so it wraps naturally.
            if (state == ST_LOAD) begin
                in_addr_q <= in_addr_q + 1'b1;
            end
            if (out_step) begin
                out_addr_q <= out_last ? '0 : out_addr_q + 1'b1;
                if (out_last && batch_q != last_batch_q) begin
                    batch_q <= batch_q + 8'd1;
                end
            end
        end
    end

    always_comb begin
        busy      = (state != ST_IDLE);
        done      = (state == ST_DONE);
        in_en     = (state == ST_LOAD);
        in_addr   = (state == ST_IDLE) ? '0 : in_addr_q;
        out_en    = '0;
        out_we    = '0;
        out_addr  = '0;
        out_valid = 1'b0;
        drv_en    = 1'b0;
        batch_idx = (state == ST_IDLE) ? 8'd0 : batch_q;
        if (state == ST_WAIT) begin
            out_en = mask_q;
            drv_en = (cnt < LEAD_CNT);
        end
        if (state == ST_OUT) begin
            out_en    = mask_q;
            out_addr  = out_addr_q;
            out_we    = out_stall ? '0 : mask_q;
            out_valid = !out_stall;
            drv_en    = ({1'b0, out_addr_q} < DRV_STOP);
        end
    end

endmodule

// File: tb/tb_spmv_seq_ctrl.sv
// Directed bench for spmv_seq_ctrl: expected result writes are queued at start and popped as the DUT writes.
module tb_spmv_seq_ctrl;

    localparam int OUT_DEPTH = 1024;
    localparam int LAT       = 84;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [7:0] cfg_batches = 8'd0;
    logic [3:0] ch_mask = 4'd0;
    logic       out_stall = 1'b0;

    logic        busy, done, in_en, out_valid, drv_en;
    logic [7:0]  in_addr, batch_idx;
    logic [3:0]  out_en, out_we;
    logic [10:0] out_addr;

    spmv_seq_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .abort       (abort),
        .cfg_batches (cfg_batches),
        .ch_mask     (ch_mask),
        .out_stall   (out_stall),
        .busy        (busy),
        .done        (done),
        .in_en       (in_en),
        .in_addr     (in_addr),
        .out_en      (out_en),
        .out_we      (out_we),
        .out_addr    (out_addr),
        .out_valid   (out_valid),
        .drv_en      (drv_en),
        .batch_idx   (batch_idx)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         addr;
        logic [3:0] m;
        int         b;
    } exp_t;

    exp_t       sb[$];
    exp_t       mon_e;
    int         total = 0;
    int         bad = 0;
    int         done_cnt = 0;
    int         exp_done = 0;
    logic [7:0] exp_in = 8'd0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Monitor: input address model, done counting, and scoreboard pops on each write.
    always @(negedge clk) begin
        if (!rst) begin
            if (!busy) exp_in = 8'd0;
            if (done) begin
                done_cnt++;
                check("done_busy", busy, 1);
            end
            if (in_en) begin
                check("in_addr", in_addr, exp_in);
                exp_in = exp_in + 8'd1;
            end
            if (out_valid) begin
                if (sb.size() == 0) begin
                    check("sb_unexpected_write", 0, 1);
                end else begin
                    mon_e = sb.pop_front();
                    check("wr_addr", out_addr, mon_e.addr);
                    check("wr_we", out_we, mon_e.m);
                    check("wr_en", out_en, mon_e.m);
                    check("wr_batch", batch_idx, mon_e.b);
                    check("wr_drv", drv_en, (mon_e.addr < OUT_DEPTH - 2) ? 1 : 0);
                end
            end else begin
                check("we_no_valid", out_we, 0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_in_en"}, in_en, 0);
        check({tag, "_in_addr"}, in_addr, 0);
        check({tag, "_out_en"}, out_en, 0);
        check({tag, "_out_we"}, out_we, 0);
        check({tag, "_out_addr"}, out_addr, 0);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_drv_en"}, drv_en, 0);
        check({tag, "_batch_idx"}, batch_idx, 0);
    endtask

    // Drives start, queues the expected writes, and checks the phase timeline up to the first write.
    task automatic start_job(input logic [7:0] nb, input logic [3:0] m, input string tag);
        int eff;
        eff = (nb == 8'd0) ? 1 : int'(nb);
        for (int b = 0; b < eff; b++)
            for (int a = 0; a < OUT_DEPTH; a++)
                sb.push_back('{a, m, b});
        cfg_batches = nb;
        ch_mask = m;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= LAT; c++) begin
            @(negedge clk);
            if (c < LAT) begin
                check({tag, "_lat_valid"}, out_valid, 0);
                check({tag, "_lat_busy"}, busy, 1);
                check({tag, "_lat_in_en"}, in_en, (c <= 64) ? 1 : 0);
                check({tag, "_lat_out_en"}, out_en, (c >= 68) ? m : 4'd0);
                check({tag, "_lat_drv"}, drv_en, (c >= 82) ? 1 : 0);
            end else begin
                check({tag, "_first_write"}, out_valid, 1);
            end
        end
    endtask

    task automatic wait_addr(input int addr, input int budget, input string tag);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < budget && !hit; i++) begin
            @(negedge clk);
            if (out_valid && out_addr == 11'(addr)) hit = 1'b1;
        end
        check({tag, "_reach_addr"}, hit, 1);
    endtask

    task automatic finish_job(input int budget, input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        check({tag, "_done_seen"}, seen, 1);
        exp_done++;
        @(negedge clk);
        check({tag, "_sb_drained"}, sb.size(), 0);
        check({tag, "_done_count"}, done_cnt, exp_done);
        check_idle({tag, "_idle"});
    endtask

    initial begin
        // Reset held for three cycles
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        @(negedge clk);
        check_idle("reset");

        // Abort while idle does nothing
        abort = 1'b1;
        tick();
        abort = 1'b0;
        @(negedge clk);
        check_idle("abort_idle");

        // Single batch, all channels
        start_job(8'd1, 4'hF, "one");
        finish_job(1200, "one");

        // Three batches: in_addr continues, out_addr restarts, one done
        start_job(8'd3, 4'hF, "three");
        finish_job(3 * 1200, "three");

        // Five-cycle stall holding out_addr at 100
        start_job(8'd1, 4'hF, "stall");
        wait_addr(99, 300, "stall");
        tick();
        out_stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_addr", out_addr, 100);
            check("stall_we", out_we, 0);
            check("stall_valid", out_valid, 0);
            check("stall_en", out_en, 4'hF);
            check("stall_drv", drv_en, 1);
        end
        tick();
        out_stall = 1'b0;
        finish_job(1200, "stall");

        // Abort during WAIT
        sb.delete();
        cfg_batches = 8'd1;
        ch_mask = 4'hF;
        for (int a = 0; a < OUT_DEPTH; a++) sb.push_back('{a, 4'hF, 0});
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (70) @(negedge clk);
        check("abw_in_wait", out_en, 4'hF);
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        @(negedge clk);
        check_idle("abw");
        check("abw_no_writes", sb.size(), OUT_DEPTH);
        check("abw_no_done", done_cnt, exp_done);
        sb.delete();

        // Abort during OUT; the write in the abort cycle still lands
        start_job(8'd1, 4'hF, "abo");
        wait_addr(50, 200, "abo");
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        @(negedge clk);
        check_idle("abo");
        check("abo_writes_left", sb.size(), OUT_DEPTH - 52);
        check("abo_no_done", done_cnt, exp_done);
        sb.delete();

        // Clean job after abort
        start_job(8'd1, 4'hF, "clean");
        finish_job(1200, "clean");

        // Partial mask, start pulses while busy and in the DONE cycle
        start_job(8'd1, 4'b0101, "mask");
        wait_addr(10, 100, "mask");
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_addr(1022, 1100, "mask");
        tick();
        tick();
        start = 1'b1;
        @(negedge clk);
        check("mask_done_cycle", done, 1);
        tick();
        start = 1'b0;
        exp_done++;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("mask_stays_idle", busy, 0);
        end
        check("mask_sb_drained", sb.size(), 0);
        check("mask_done_count", done_cnt, exp_done);

        // Zero batches behaves as one; zero mask still sequences and completes
        start_job(8'd0, 4'b0000, "zero");
        finish_job(1200, "zero");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

endmodule
